// File: rtl/updown_counter_pkg.sv
// updown_counter_pkg: shared constants, step-action encoding and sizing helper for the
// parametrised up/down counter and its optional enable prescaler.
package updown_counter_pkg;

   // Direction and end-of-range mode encodings seen on i_up_dn / i_mode_sat
   localparam logic DIR_UP    = 1'b1;
   localparam logic DIR_DN    = 1'b0;
   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;

   // What the counter does on a given edge, decoded once from load/step/dir/mode/position
   typedef enum logic [2:0] {
      ActHold,
      ActLoad,
      ActLoadClip,
      ActInc,
      ActDec,
      ActWrapUp,
      ActWrapDn,
      ActSat
   } act_e;

   // ceil(log2(n)), never less than 1 so a register sized from it is always legal
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned v;
      int unsigned r;
      v = (n > 0) ? n - 1 : 0;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((v >> i) != 0) begin
            r = i + 1;
         end
      end
      return (r == 0) ? 1 : r;
   endfunction

endpackage

// File: rtl/count_prescaler.sv
// count_prescaler: divides a level enable into a one-edge step strobe every PRESCALE_DIV
// enabled edges. Only instantiated when COUNTER_PRESCALE_EN is defined.
module count_prescaler
   import updown_counter_pkg::*;
#(
   parameter int unsigned PRESCALE_DIV = 4
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_en,
   input  logic i_clr,
   output logic o_step
);

   localparam int unsigned PW = clog2(PRESCALE_DIV);
   localparam logic [PW-1:0] LAST = PW'(PRESCALE_DIV - 1);
   localparam logic [PW-1:0] ONE  = PW'(1);

   logic [PW-1:0] r_cnt;
   logic          w_at_last;

   assign w_at_last = (r_cnt == LAST);
   // Step is only meaningful when not cleared; the counter gives load priority anyway
   assign o_step    = i_en && w_at_last;

   // Prescale count: clear on load, freeze when disabled, roll to 0 after the last phase
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= w_at_last ? '0 : r_cnt + ONE;
      end
   end

endmodule

// File: rtl/updown_counter_param.sv
// updown_counter_param: up/down modulo-MODULO counter with synchronous load, count enable,
// wrap or saturate at the range ends, combinational terminal count, registered one-cycle
// wrap pulse and a sticky overflow flag.
// Build option: define COUNTER_PRESCALE_EN to advance the counter only once every
// PRESCALE_DIV enabled edges; without it the counter steps on every enabled edge.
module updown_counter_param
   import updown_counter_pkg::*;
#(
   parameter int unsigned     WIDTH        = 4,
   parameter longint unsigned MODULO       = 16,
   parameter int unsigned     PRESCALE_DIV = 4
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_en,
   input  logic             i_up_dn,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   input  logic             i_mode_sat,
   input  logic             i_clr_ovf,
   output logic [WIDTH-1:0] o_count,
   output logic             o_tc,
   output logic             o_wrap,
   output logic             o_ovf
);

   // Top of range held in WIDTH+1 bits so MODULO = 2^WIDTH stays representable
   localparam logic [WIDTH:0]   LAST   = (WIDTH + 1)'(MODULO - 64'd1);
   localparam logic [WIDTH-1:0] LAST_W = LAST[WIDTH-1:0];
   localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

   if (WIDTH < 2 || WIDTH > 32 || MODULO < 2 || MODULO > (64'd1 << WIDTH) ||
       PRESCALE_DIV < 2 || PRESCALE_DIV > 256) begin : g_param_check
      $error("updown_counter_param: illegal WIDTH/MODULO/PRESCALE_DIV combination");
   end

   logic [WIDTH-1:0] r_count;
   logic             r_wrap;
   logic             r_ovf;

   logic             w_step;
   logic             w_at_max;
   logic             w_at_zero;
   logic             w_load_clip;
   act_e             w_act;
   logic [WIDTH-1:0] w_count_nxt;
   logic             w_wrap_nxt;
   logic             w_set_ovf;
   logic             w_ovf_nxt;

`ifdef COUNTER_PRESCALE_EN
   count_prescaler #(
      .PRESCALE_DIV (PRESCALE_DIV)
   ) u_prescaler (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_en    (i_en),
      .i_clr   (i_load),
      .o_step  (w_step)
   );
`else
   assign w_step = i_en;
`endif

   assign w_at_max    = ({1'b0, r_count} == LAST);
   assign w_at_zero   = (r_count == '0);
   assign w_load_clip = ({1'b0, i_load_val} > LAST);

   // Decode the edge's action: load beats a count step, which beats hold
   always_comb begin
      w_act = ActHold;
      if (i_load) begin
         w_act = w_load_clip ? ActLoadClip : ActLoad;
      end else if (w_step) begin
         if (i_up_dn == DIR_UP) begin
            if (!w_at_max) begin
               w_act = ActInc;
            end else if (i_mode_sat == MODE_WRAP) begin
               w_act = ActWrapUp;
            end else begin
               w_act = ActSat;
            end
         end else begin
            if (!w_at_zero) begin
               w_act = ActDec;
            end else if (i_mode_sat == MODE_SAT) begin
               w_act = ActSat;
            end else begin
               w_act = ActWrapDn;
            end
         end
      end
   end

   // Next count, wrap pulse and overflow-set event for the decoded action
   always_comb begin
      w_count_nxt = r_count;
      w_wrap_nxt  = 1'b0;
      w_set_ovf   = 1'b0;
      unique case (w_act)
         ActLoad: begin
            w_count_nxt = i_load_val;
         end
         ActLoadClip: begin
            w_count_nxt = LAST_W;
            w_set_ovf   = 1'b1;
         end
         ActInc: begin
            w_count_nxt = r_count + ONE;
         end
         ActDec: begin
            w_count_nxt = r_count - ONE;
         end
         ActWrapUp: begin
            w_count_nxt = '0;
            w_wrap_nxt  = 1'b1;
            w_set_ovf   = 1'b1;
         end
         ActWrapDn: begin
            w_count_nxt = LAST_W;
            w_wrap_nxt  = 1'b1;
            w_set_ovf   = 1'b1;
         end
         ActSat: begin
            w_set_ovf   = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // A set event on the same edge as clr_ovf wins
   assign w_ovf_nxt = w_set_ovf ? 1'b1 : (i_clr_ovf ? 1'b0 : r_ovf);

   // Counter state and registered flags
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_count <= '0;
         r_wrap  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_count <= w_count_nxt;
         r_wrap  <= w_wrap_nxt;
         r_ovf   <= w_ovf_nxt;
      end
   end

   assign o_count = r_count;
   assign o_wrap  = r_wrap;
   assign o_ovf   = r_ovf;
   assign o_tc    = ((i_up_dn == DIR_UP) && w_at_max) || ((i_up_dn == DIR_DN) && w_at_zero);

endmodule

// File: tb/tb_updown_counter_param.sv
// tb_updown_counter_param: self-checking bench for updown_counter_param with WIDTH=4,
// MODULO=10. Directed table, hand-written corner sequences, then randomized stimulus
// against an arithmetic reference model. Prescale checks run when COUNTER_PRESCALE_EN
// is defined (PRESCALE_DIV=4).
module tb_updown_counter_param;

   localparam int unsigned     WIDTH        = 4;
   localparam longint unsigned MODULO       = 10;
   localparam int unsigned     PRESCALE_DIV = 4;
   localparam int              MOD          = 10;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             en = 1'b0;
   logic             up_dn = 1'b0;
   logic             load = 1'b0;
   logic [WIDTH-1:0] load_val = '0;
   logic             mode_sat = 1'b0;
   logic             clr_ovf = 1'b0;
   logic [WIDTH-1:0] count;
   logic             tc;
   logic             wrap;
   logic             ovf;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   int m_count;
   bit m_wrap;
   bit m_ovf;
   int m_psc;

   always #5 clk = ~clk;

   updown_counter_param #(
      .WIDTH        (WIDTH),
      .MODULO       (MODULO),
      .PRESCALE_DIV (PRESCALE_DIV)
   ) u_dut (
      .i_clk      (clk),
      .i_reset    (rst),
      .i_en       (en),
      .i_up_dn    (up_dn),
      .i_load     (load),
      .i_load_val (load_val),
      .i_mode_sat (mode_sat),
      .i_clr_ovf  (clr_ovf),
      .o_count    (count),
      .o_tc       (tc),
      .o_wrap     (wrap),
      .o_ovf      (ovf)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_count = 0;
      m_wrap  = 1'b0;
      m_ovf   = 1'b0;
      m_psc   = 0;
   endtask

   // One clock edge of the specified behaviour, in plain integer arithmetic
   task automatic model_edge(input logic ld, input int lv, input logic e, input logic ud,
                             input logic ms, input logic co);
      bit set_ev;
      bit wr;
      bit go;
      set_ev = 1'b0;
      wr     = 1'b0;
      go     = 1'b0;
      if (ld) begin
         m_count = (lv >= MOD) ? MOD - 1 : lv;
         set_ev  = (lv >= MOD);
         m_psc   = 0;
      end else if (e) begin
`ifdef COUNTER_PRESCALE_EN
         m_psc = (m_psc + 1) % PRESCALE_DIV;
         go    = (m_psc == 0);
`else
         go    = 1'b1;
`endif
         if (go) begin
            if (ud) begin
               if (m_count == MOD - 1) begin
                  set_ev = 1'b1;
                  if (!ms) begin
                     m_count = 0;
                     wr      = 1'b1;
                  end
               end else begin
                  m_count = m_count + 1;
               end
            end else begin
               if (m_count == 0) begin
                  set_ev = 1'b1;
                  if (!ms) begin
                     m_count = MOD - 1;
                     wr      = 1'b1;
                  end
               end else begin
                  m_count = m_count - 1;
               end
            end
         end
      end
      m_wrap = wr;
      if (set_ev) m_ovf = 1'b1;
      else if (co) m_ovf = 1'b0;
   endtask

   task automatic check_model(input string tag);
      logic exp_tc;
      exp_tc = (up_dn && m_count == MOD - 1) || (!up_dn && m_count == 0);
      check({tag, ".count"}, 32'(count), 32'(m_count));
      check({tag, ".wrap"}, 32'(wrap), 32'(m_wrap));
      check({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
      check({tag, ".tc"}, 32'(tc), 32'(exp_tc));
   endtask

   // Drive one cycle of inputs, let one rising edge pass, and advance the model
   task automatic apply(input logic ld, input logic [WIDTH-1:0] lv, input logic e,
                        input logic ud, input logic ms, input logic co);
      load     = ld;
      load_val = lv;
      en       = e;
      up_dn    = ud;
      mode_sat = ms;
      clr_ovf  = co;
      @(posedge clk);
      #1;
      model_edge(ld, int'(lv), e, ud, ms, co);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      load = 1'b0; en = 1'b0; clr_ovf = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      model_reset();
   endtask

   typedef struct {
      logic             ld;
      logic [WIDTH-1:0] lv;
      logic             e;
      logic             ud;
      logic             ms;
      logic             co;
      int               exp_count;
      logic             exp_wrap;
      logic             exp_ovf;
      logic             exp_tc;
   } vec_t;

   vec_t vecs[15];

   initial begin
      // ld  lv     en  ud  ms  co   count wrap ovf tc
      vecs[0]  = '{1'b1, 4'd9,  1'b1, 1'b1, 1'b0, 1'b0, 9, 1'b0, 1'b0, 1'b1};
      vecs[1]  = '{1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0};
      vecs[2]  = '{1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0};
      vecs[3]  = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 1'b1, 9, 1'b1, 1'b1, 1'b0};
      vecs[4]  = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 9, 1'b0, 1'b0, 1'b0};
      vecs[5]  = '{1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1};
      vecs[6]  = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b1};
      vecs[7]  = '{1'b1, 4'd5,  1'b1, 1'b1, 1'b0, 1'b0, 5, 1'b0, 1'b1, 1'b0};
      vecs[8]  = '{1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 1'b0, 6, 1'b0, 1'b1, 1'b0};
      vecs[9]  = '{1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 1'b1, 6, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{1'b1, 4'd12, 1'b0, 1'b1, 1'b0, 1'b0, 9, 1'b0, 1'b1, 1'b1};
      vecs[11] = '{1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 1'b0, 9, 1'b0, 1'b1, 1'b1};
      vecs[12] = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 1'b0, 8, 1'b0, 1'b1, 1'b0};
      vecs[13] = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 8, 1'b0, 1'b0, 1'b0};
      vecs[14] = '{1'b1, 4'd15, 1'b0, 1'b0, 1'b0, 1'b1, 9, 1'b0, 1'b1, 1'b0};

      // Reset state while reset is held low
      @(posedge clk);
      #1;
      check("rst.count", 32'(count), 32'd0);
      check("rst.wrap", 32'(wrap), 32'd0);
      check("rst.ovf", 32'(ovf), 32'd0);
      rst = 1'b1;
      model_reset();

      // Asynchronous reset mid-count: get ovf set and count at 7, then pull reset low
      apply(1'b1, 4'd12, 1'b0, 1'b1, 1'b0, 1'b0);
      check("clip.count", 32'(count), 32'd9);
      check("clip.ovf", 32'(ovf), 32'd1);
      apply(1'b1, 4'd7, 1'b1, 1'b1, 1'b0, 1'b0);
      check("pre_rst.count", 32'(count), 32'd7);
      load = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      check("async_rst.count", 32'(count), 32'd0);
      check("async_rst.wrap", 32'(wrap), 32'd0);
      check("async_rst.ovf", 32'(ovf), 32'd0);
      @(posedge clk);
      #1;
      check("rst_hold.count", 32'(count), 32'd0);
      rst = 1'b1;
      model_reset();
`ifndef COUNTER_PRESCALE_EN
      for (int k = 1; k <= 3; k++) begin
         apply(1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
         check("post_rst.count", 32'(count), 32'(k));
      end

      // Directed table from reset
      do_reset();
      for (int i = 0; i < 15; i++) begin
         apply(vecs[i].ld, vecs[i].lv, vecs[i].e, vecs[i].ud, vecs[i].ms, vecs[i].co);
         check($sformatf("vec%0d.count", i), 32'(count), 32'(vecs[i].exp_count));
         check($sformatf("vec%0d.wrap", i), 32'(wrap), 32'(vecs[i].exp_wrap));
         check($sformatf("vec%0d.ovf", i), 32'(ovf), 32'(vecs[i].exp_ovf));
         check($sformatf("vec%0d.tc", i), 32'(tc), 32'(vecs[i].exp_tc));
      end
`else
      // Prescale: 12 enabled edges from 0 step the counter on edges 4, 8 and 12
      for (int k = 1; k <= 12; k++) begin
         apply(1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
         check($sformatf("psc%0d.count", k), 32'(count), 32'(k / 4));
      end
      // en low freezes the prescaler; load clears it
      apply(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      apply(1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      apply(1'b1, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0);
      for (int k = 1; k <= 4; k++) begin
         apply(1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
         check($sformatf("psc_ld%0d.count", k), 32'(count), (k == 4) ? 32'd3 : 32'd2);
      end
      for (int i = 0; i < 15; i++) begin
         apply(vecs[i].ld, vecs[i].lv, vecs[i].e, vecs[i].ud, vecs[i].ms, vecs[i].co);
         check_model($sformatf("vec%0d", i));
      end
`endif

      // Randomized stimulus against the reference model
      do_reset();
      for (int i = 0; i < 600; i++) begin
         apply(($urandom_range(0, 7) == 0), WIDTH'($urandom_range(0, 15)),
               ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
               ($urandom_range(0, 3) == 0));
         check_model("rand");
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
